bcd_countdown_timer: RTL and testbench

Parametrised multi-digit BCD countdown timer for the game/access-control path. It combines a clock prescaler with an N-digit BCD down-counter and supports load, pause/resume and sticky timeout. It replaces the fixed one-digit/ten-second timer pair. It feeds digit nibbles to the 7-segment decoders and TimeOut to the access controller.

---
 rtl/bcd_countdown_timer_pkg.sv | 25 ++
 rtl/bcd_countdown_timer_tick_prescaler.sv | 41 ++++
 rtl/bcd_countdown_timer.sv | 167 ++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared state encodings, BCD limit and per-digit clamp helper for the countdown timer.
// Optional AUTO_RELOAD_EN (see top) changes expiry into a reload; nothing here depends on it.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } timer_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Any non-decimal nibble is saturated to 9 so the counter never holds an illegal digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter; holds while run=0, clear has priority.
// Configuration: none (shared by both AUTO_RELOAD_EN builds).
module tick_prescaler #(
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick_raw
);

  localparam logic [PRESC_W-1:0] LAST  = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] ZERO  = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);

  logic [PRESC_W-1:0] count_r;
  logic               at_last_s;

  assign at_last_s = (count_r == LAST);
  assign tick_raw  = run && at_last_s && !clear;

  // Prescaler count register: wraps at TICK_DIV-1, frozen when not running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= ZERO;
    end else if (clear) begin
      count_r <= ZERO;
    end else if (run) begin
      if (at_last_s) begin
        count_r <= ZERO;
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with load, pause/resume and timeout flag.
// Define AUTO_RELOAD_EN to reload the last loaded value on expiry instead of stopping.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int NUM_DIGITS = 2,
  parameter int PRESC_W    = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    reconfig,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    TimeOut
);

  localparam int              DW   = 4 * NUM_DIGITS;
  localparam logic [DW-1:0]   ZERO = {DW{1'b0}};

  timer_state_e  state_r, state_nxt_s;
  logic [DW-1:0] digits_r, digits_nxt_s;
  logic [DW-1:0] dec_s, load_clamp_s;
  logic          borrow_s;
  logic          tick_r, tick_nxt_s;
  logic          timeout_r, timeout_nxt_s;
  logic          run_s, tick_raw_s;

  // Counting continues straight out of PAUSE so a resume picks up the held phase.
  assign run_s = enable && !reconfig && ((state_r == RUN) || (state_r == PAUSE));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (run_s),
    .clear    (reconfig),
    .tick_raw (tick_raw_s)
  );

  // Clamp each incoming nibble to a legal decimal digit.
  always_comb begin
    load_clamp_s = ZERO;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clamp_s[4*i +: 4] = clamp_digit(load_bcd[4*i +: 4]);
    end
  end

  // BCD decrement: a digit borrows only while every lower digit is zero.
  always_comb begin
    dec_s    = digits_r;
    borrow_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow_s) begin
        if (digits_r[4*i +: 4] == 4'd0) begin
          dec_s[4*i +: 4] = BCD_MAX;
          borrow_s        = 1'b1;
        end else begin
          dec_s[4*i +: 4] = digits_r[4*i +: 4] - 4'd1;
          borrow_s        = 1'b0;
        end
      end else begin
        dec_s[4*i +: 4] = digits_r[4*i +: 4];
      end
    end
  end

`ifdef AUTO_RELOAD_EN
  logic [DW-1:0] reload_r;

  // Capture of the last (clamped) load value for auto-reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_r <= ZERO;
    end else if (reconfig) begin
      reload_r <= load_clamp_s;
    end else begin
      reload_r <= reload_r;
    end
  end
`endif

  // Next-state and next-output logic; reconfig outranks expiry, which outranks enable.
  always_comb begin
    state_nxt_s   = state_r;
    digits_nxt_s  = digits_r;
    tick_nxt_s    = 1'b0;
    timeout_nxt_s = timeout_r;
    if (reconfig) begin
      state_nxt_s   = IDLE;
      digits_nxt_s  = load_clamp_s;
      timeout_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            if (digits_r == ZERO) begin
              state_nxt_s   = EXPIRED;
              timeout_nxt_s = 1'b1;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN, PAUSE: begin
          timeout_nxt_s = 1'b0;
          if (tick_raw_s) begin
            tick_nxt_s   = 1'b1;
            digits_nxt_s = dec_s;
            if (dec_s == ZERO) begin
              timeout_nxt_s = 1'b1;
`ifdef AUTO_RELOAD_EN
              if (reload_r != ZERO) begin
                digits_nxt_s = reload_r;
                state_nxt_s  = RUN;
              end else begin
                state_nxt_s = EXPIRED;
              end
`else
              state_nxt_s = EXPIRED;
`endif
            end else begin
              state_nxt_s = RUN;
            end
          end else if (enable) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = PAUSE;
          end
        end
        EXPIRED: begin
          digits_nxt_s  = ZERO;
          timeout_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      digits_r  <= ZERO;
      tick_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      digits_r  <= digits_nxt_s;
      tick_r    <= tick_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign digits  = digits_r;
  assign tick    = tick_r;
  assign TimeOut = timeout_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (TICK_DIV=4, NUM_DIGITS=2).
// Expected ticks are queued by the stimulus and checked by an independent monitor.
module tb_bcd_countdown_timer;

  localparam int TD = 4;
  localparam int ND = 2;
  localparam int PW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        reconfig = 1'b0;
  logic [7:0]  load_bcd = 8'h00;
  logic [7:0]  digits;
  logic        tick;
  logic        TimeOut;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rec = 0;

  typedef struct {
    int         cyc;
    logic [7:0] dig;
    logic       to;
  } exp_t;

  exp_t sb[$];

  bcd_countdown_timer #(
    .TICK_DIV   (TD),
    .NUM_DIGITS (ND),
    .PRESC_W    (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .reconfig (reconfig),
    .load_bcd (load_bcd),
    .digits   (digits),
    .tick     (tick),
    .TimeOut  (TimeOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_tick(input int c, input logic [7:0] dig, input logic to);
    exp_t e;
    e.cyc = c;
    e.dig = dig;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One-cycle reconfig; rec is the cycle of the loading edge, enable applies from rec+1.
  task automatic load(input logic [7:0] v, input logic en_after);
    @(negedge clk);
    reconfig = 1'b1;
    load_bcd = v;
    @(negedge clk);
    reconfig = 1'b0;
    enable   = en_after;
    rec      = cyc;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d ticks still pending", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every tick pops one expectation; an overdue expectation is a missed tick.
  always @(negedge clk) begin
    if (rst) begin
      if (tick) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: got tick with digits %0h, required none (cycle %0d)", digits, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tick_cycle", cyc, e.cyc);
          chk("tick_digits", {24'd0, digits}, {24'd0, e.dig});
          chk("tick_timeout", {31'd0, TimeOut}, {31'd0, e.to});
        end
      end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_tick: no tick at cycle %0d, required digits %0h", sb[0].cyc, sb[0].dig);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_digits", {24'd0, digits}, 32'h0);
    chk("reset_tick", {31'd0, tick}, 32'h0);
    chk("reset_timeout", {31'd0, TimeOut}, 32'h0);
    rst = 1'b1;

`ifndef AUTO_RELOAD_EN
    load(8'h12, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      expect_tick(rec + 1 + TD * k, to_bcd(12 - k), (k == 12));
    end
    drain(60);
    repeat (3) @(negedge clk);
    chk("expired_digits", {24'd0, digits}, 32'h0);
    chk("expired_timeout", {31'd0, TimeOut}, 32'h1);
`else
    load(8'h02, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      expect_tick(rec + 1 + TD * k, (k % 2 == 1) ? 8'h01 : 8'h02, (k % 2 == 0));
    end
    wait_until(rec + 18);
    chk("reload_timeout_pulse_end", {31'd0, TimeOut}, 32'h0);
    chk("reload_queue_empty", sb.size(), 32'h0);
`endif

    load(8'h10, 1'b1);
    expect_tick(rec + 5, 8'h09, 1'b0);
    expect_tick(rec + 9, 8'h08, 1'b0);
    wait_until(rec + 11);
    enable = 1'b0;
    wait_until(rec + 16);
    chk("pause_digits", {24'd0, digits}, 32'h08);
    wait_until(rec + 21);
    enable = 1'b1;
    expect_tick(rec + 23, 8'h07, 1'b0);

    wait_until(rec + 26);
    reconfig = 1'b1;
    load_bcd = 8'h30;
    @(negedge clk);
    reconfig = 1'b0;
    chk("reconfig_digits", {24'd0, digits}, 32'h30);
    chk("reconfig_tick", {31'd0, tick}, 32'h0);
    chk("reconfig_queue_empty", sb.size(), 32'h0);

    wait_until(rec + 30);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_digits", {24'd0, digits}, 32'h0);
    chk("async_reset_tick", {31'd0, tick}, 32'h0);
    chk("async_reset_timeout", {31'd0, TimeOut}, 32'h0);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;

    load(8'h00, 1'b1);
    @(negedge clk);
    chk("zero_load_timeout", {31'd0, TimeOut}, 32'h1);
    chk("zero_load_digits", {24'd0, digits}, 32'h0);
    repeat (3) @(negedge clk);
    chk("zero_load_sticky", {31'd0, TimeOut}, 32'h1);

    load(8'h05, 1'b0);
    chk("reload5_timeout", {31'd0, TimeOut}, 32'h0);
    chk("reload5_digits", {24'd0, digits}, 32'h05);

    load(8'hAF, 1'b0);
    chk("clamp_digits", {24'd0, digits}, 32'h99);
    repeat (4) @(negedge clk);
    chk("final_queue_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
